sprite_compositor: RTL and testbench
====================================

// Module: sprite_compositor
// PURPOSE
//   Receiving end of the processor's sprite stream (x, y, frame, sprite_valid). Collects the
//   sprite descriptors emitted during one frame into a double-buffered list, builds a per-scanline
//   hit list during horizontal blanking, and emits per pixel the covering sprite's animation
//   frame and local pixel offset. It sits between processor and sprite ROM / pixel mux.
// PARAMETERS
//   CANVAS_WIDTH   100  horizontal extent; x/hcount width = $clog2(CANVAS_WIDTH)
//   CANVAS_HEIGHT  100  vertical extent; y/line_y width = $clog2(CANVAS_HEIGHT)
//   NUM_FRAMES     100  animation frames; frame width = $clog2(NUM_FRAMES)
//   MAX_SPRITES    32   list entries per frame
//   SPRITE_SIZE    16   square sprite edge in pixels (power of two)
//   LINE_SPRITES   4    max sprites resolved on one scanline
// PORTS
//   pixel_clk_in      in   1     single clock
//   rst_in            in   1     asynchronous, active-high reset
//   new_frame         in   1     1-cycle pulse: swap list banks
//   x / y             in   XW/YW sprite top-left from processor
//   frame             in   FW    sprite animation frame
//   sprite_valid      in   1     descriptor strobe, one entry per cycle
//   line_start_in     in   1     1-cycle pulse at start of hblank preceding line line_y_in
//   line_y_in         in   YW    scanline about to be drawn
//   pixel_valid_in    in   1     hcount_in valid (active video)
//   hcount_in         in   XW    current pixel column
//   sprite_hit_out    out  1     pixel covered by a sprite
//   sprite_frame_out  out  FW    frame of winning sprite
//   sprite_px_out     out  $clog2(SPRITE_SIZE)  column within sprite
//   sprite_py_out     out  $clog2(SPRITE_SIZE)  row within sprite
//   line_ready_out    out  1     hit list for current line complete
//   list_ovf_out      out  1     sticky: >MAX_SPRITES descriptors in a frame
//   line_ovf_out      out  1     sticky per line: >LINE_SPRITES sprites on line
// BEHAVIOUR
//   Reset: all outputs 0, both bank counts 0, write bank 0, scanner IDLE, line list empty.
//   Capture: sprite_valid appends {x,y,frame} to back bank at wr_cnt; wr_cnt increments.
//     wr_cnt==MAX_SPRITES -> drop entry, set list_ovf_out (held until next new_frame).
//   Swap on new_frame: back becomes front, front_cnt<=wr_cnt, wr_cnt<=0, list_ovf_out<=0.
//     sprite_valid in same cycle as new_frame -> entry written to new back bank index 0.
//     new_frame also aborts any scan: scanner -> IDLE, line list cleared, line_ready_out<=0.
//   Scanner FSM IDLE -> SCAN -> DONE:
//     line_start_in: latch line_y_in, clear line list and line_ovf_out, idx<=0, line_ready_out<=0,
//       -> SCAN (from any state; mid-scan restarts).
//     SCAN: one front entry per cycle; hit iff line_y - y in [0,SPRITE_SIZE) (unsigned, YW+1 bits,
//       no wrap). Hits appended in list order; hit when list full sets line_ovf_out, entry dropped.
//     idx==front_cnt -> DONE, line_ready_out<=1. front_cnt==0 -> DONE after 1 cycle.
//     Scan takes front_cnt+1 cycles; hblank >= MAX_SPRITES+2 cycles is a system guarantee.
//   Pixel path, latency 1 cycle (registered outputs):
//     hit when pixel_valid_in, state DONE, and some line entry has hcount - x in [0,SPRITE_SIZE)
//       (XW+1 bits unsigned). Lowest line-list index (earliest emitted) wins.
//     px = (hcount - x) low bits, py = (line_y - y) low bits, frame = winner's frame.
//     No hit / not DONE / pixel_valid_in low: sprite_hit_out=0, other pixel outputs 0.
//   Sprites extending past right/bottom edge clip naturally; coordinates never negative.
// STRUCTURE
//   sprite_pkg: sprite_t {x,y,frame} parameterised via localparams, SPRITE_SIZE, scan_state_t enum.
//   Sub-module sprite_line_scanner: FSM + line list (front-bank read port, line_y compare).
//   Top holds both banks (register arrays, bank select bit) and the priority pixel compare.
// TESTING
//   1) Reset mid-frame after 3 writes -> all outputs 0, front_cnt 0, line_ready_out 0 next edge.
//   2) Frame A: sprite (10,20,f5); new_frame; line_start y=25 -> line_ready_out after 2 cycles;
//      hcount=13 -> next cycle hit=1, frame=5, px=3, py=5; hcount=26 -> hit=0.
//   3) Overlap: (10,20,f1) then (12,20,f2); line 20, hcount=12 -> frame=1 (priority); hcount=26
//      -> frame=2, px=14.
//   4) 6 sprites all at y=0, LINE_SPRITES=4; line 0 -> line_ovf_out=1, only first 4 hit;
//      33 writes in a frame -> list_ovf_out=1, cleared by new_frame.
//   5) sprite_valid coincident with new_frame -> entry appears only after the following swap.
//   6) line_start_in during SCAN restarts; new_frame during SCAN -> IDLE, hit=0 until next line.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared widths, sprite descriptor layout and scanner state encoding for the sprite compositor.
package sprite_compositor_pkg;

   localparam int CANVAS_WIDTH  = 100;
   localparam int CANVAS_HEIGHT = 100;
   localparam int NUM_FRAMES    = 100;
   localparam int MAX_SPRITES   = 32;
   localparam int SPRITE_SIZE   = 16;
   localparam int LINE_SPRITES  = 4;

   localparam int XW  = $clog2(CANVAS_WIDTH);
   localparam int YW  = $clog2(CANVAS_HEIGHT);
   localparam int FW  = $clog2(NUM_FRAMES);
   localparam int SW  = $clog2(SPRITE_SIZE);
   localparam int CW  = $clog2(MAX_SPRITES + 1);
   localparam int IW  = $clog2(MAX_SPRITES);
   localparam int LW  = $clog2(LINE_SPRITES + 1);
   localparam int LIW = $clog2(LINE_SPRITES);
   localparam int DW  = ((XW > YW) ? XW : YW) + 1;

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [FW-1:0] frame;
   } sprite_t;

   typedef enum logic [1:0] {
      SCAN_IDLE = 2'd0,
      SCAN_RUN  = 2'd1,
      SCAN_DONE = 2'd2
   } scan_state_t;

   // One extra bit keeps pos < org from wrapping into the sprite window.
   function automatic logic in_span(input logic [DW-1:0] pos_i, input logic [DW-1:0] org_i);
      logic [DW-1:0] diff;
      diff = pos_i - org_i;
      return (diff < DW'(SPRITE_SIZE));
   endfunction

endpackage

// File: rtl/sprite_compositor_line_scanner.sv
// Walks the front sprite list during hblank and keeps the first LINE_SPRITES sprites covering the line.
module sprite_compositor_line_scanner
   import sprite_compositor_pkg::*;
(
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           new_frame_i,
   input  logic                           line_start_i,
   input  logic [YW-1:0]                  line_y_i,
   input  logic [CW-1:0]                  front_cnt_i,
   output logic [IW-1:0]                  rd_idx_o,
   input  sprite_t                        rd_entry_i,
   output logic                           line_ready_o,
   output logic                           line_ovf_o,
   output logic [YW-1:0]                  line_y_o,
   output logic [LW-1:0]                  line_cnt_o,
   output sprite_t [LINE_SPRITES-1:0]     line_list_o
);

   scan_state_t                 state_q, state_d;
   logic [YW-1:0]               line_y_q, line_y_d;
   logic [CW-1:0]               idx_q, idx_d;
   logic [LW-1:0]               cnt_q, cnt_d;
   sprite_t [LINE_SPRITES-1:0]  list_q, list_d;
   logic                        ovf_q, ovf_d;
   logic                        ready_q, ready_d;
   logic                        hit_s;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SCAN_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (new_frame_i) begin
         state_d = SCAN_IDLE;
      end else if (line_start_i) begin
         state_d = SCAN_RUN;
      end else begin
         case (state_q)
            SCAN_RUN: begin
               if (idx_q == front_cnt_i) begin
                  state_d = SCAN_DONE;
               end else begin
                  state_d = SCAN_RUN;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      line_y_d = line_y_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      list_d   = list_q;
      ovf_d    = ovf_q;
      ready_d  = ready_q;
      hit_s    = in_span(DW'(line_y_q), DW'(rd_entry_i.y));
      if (new_frame_i) begin
         cnt_d   = LW'(0);
         ready_d = 1'b0;
      end else if (line_start_i) begin
         line_y_d = line_y_i;
         idx_d    = CW'(0);
         cnt_d    = LW'(0);
         ovf_d    = 1'b0;
         ready_d  = 1'b0;
      end else if (state_q == SCAN_RUN) begin
         if (idx_q == front_cnt_i) begin
            ready_d = 1'b1;
         end else begin
            idx_d = idx_q + CW'(1);
            // A hit with the line list already full is dropped but flagged.
            if (hit_s && (cnt_q == LW'(LINE_SPRITES))) begin
               ovf_d = 1'b1;
            end else if (hit_s) begin
               list_d[cnt_q[LIW-1:0]] = rd_entry_i;
               cnt_d = cnt_q + LW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
      end else begin
         ready_d = ready_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         line_y_q <= YW'(0);
         idx_q    <= CW'(0);
         cnt_q    <= LW'(0);
         list_q   <= '0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         line_y_q <= line_y_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         list_q   <= list_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
      end
   end

   assign rd_idx_o     = idx_q[IW-1:0];
   assign line_ready_o = ready_q;
   assign line_ovf_o   = ovf_q;
   assign line_y_o     = line_y_q;
   assign line_cnt_o   = cnt_q;
   assign line_list_o  = list_q;

endmodule

// File: rtl/sprite_compositor.sv
// Double-buffered sprite list capture plus per-pixel priority hit against the current line list.
module sprite_compositor
   import sprite_compositor_pkg::*;
(
   input  logic          pixel_clk_in,
   input  logic          rst_in,
   input  logic          new_frame,
   input  logic [XW-1:0] x,
   input  logic [YW-1:0] y,
   input  logic [FW-1:0] frame,
   input  logic          sprite_valid,
   input  logic          line_start_in,
   input  logic [YW-1:0] line_y_in,
   input  logic          pixel_valid_in,
   input  logic [XW-1:0] hcount_in,
   output logic          sprite_hit_out,
   output logic [FW-1:0] sprite_frame_out,
   output logic [SW-1:0] sprite_px_out,
   output logic [SW-1:0] sprite_py_out,
   output logic          line_ready_out,
   output logic          list_ovf_out,
   output logic          line_ovf_out
);

   sprite_t                    bank_q [2][MAX_SPRITES];
   logic                       wr_bank_q, wr_bank_d;
   logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]              front_cnt_q, front_cnt_d;
   logic                       list_ovf_q, list_ovf_d;
   logic                       wr_en_s, wr_sel_s;
   logic [IW-1:0]              wr_addr_s;
   logic [IW-1:0]              rd_idx_s;
   sprite_t                    rd_entry_s;
   logic                       line_ready_s;
   logic [YW-1:0]              line_y_s;
   logic [LW-1:0]              line_cnt_s;
   sprite_t [LINE_SPRITES-1:0] line_list_s;
   logic                       found_s, cov_s;
   sprite_t                    win_s;
   logic [XW-1:0]              dx_s;
   logic [YW-1:0]              dy_s;
   logic                       hit_q, hit_d;
   logic [FW-1:0]              frame_q, frame_d;
   logic [SW-1:0]              px_q, px_d, py_q, py_d;

   // On a swap the coincident descriptor lands at index 0 of the freshly freed bank.
   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      front_cnt_d = front_cnt_q;
      list_ovf_d  = list_ovf_q;
      wr_en_s     = 1'b0;
      wr_sel_s    = wr_bank_q;
      wr_addr_s   = IW'(0);
      if (new_frame) begin
         wr_bank_d   = ~wr_bank_q;
         front_cnt_d = wr_cnt_q;
         list_ovf_d  = 1'b0;
         wr_sel_s    = ~wr_bank_q;
         wr_en_s     = sprite_valid;
         wr_cnt_d    = CW'(sprite_valid);
      end else if (sprite_valid) begin
         if (wr_cnt_q == CW'(MAX_SPRITES)) begin
            list_ovf_d = 1'b1;
         end else begin
            wr_en_s   = 1'b1;
            wr_addr_s = wr_cnt_q[IW-1:0];
            wr_cnt_d  = wr_cnt_q + CW'(1);
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_bank_q   <= 1'b0;
         wr_cnt_q    <= CW'(0);
         front_cnt_q <= CW'(0);
         list_ovf_q  <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         front_cnt_q <= front_cnt_d;
         list_ovf_q  <= list_ovf_d;
      end
   end

   always_ff @(posedge pixel_clk_in) begin
      if (wr_en_s) begin
         bank_q[wr_sel_s][wr_addr_s] <= {x, y, frame};
      end
   end

   assign rd_entry_s = bank_q[~wr_bank_q][rd_idx_s];

   sprite_compositor_line_scanner u_scanner (
      .clk_i        (pixel_clk_in),
      .rst_i        (rst_in),
      .new_frame_i  (new_frame),
      .line_start_i (line_start_in),
      .line_y_i     (line_y_in),
      .front_cnt_i  (front_cnt_q),
      .rd_idx_o     (rd_idx_s),
      .rd_entry_i   (rd_entry_s),
      .line_ready_o (line_ready_s),
      .line_ovf_o   (line_ovf_out),
      .line_y_o     (line_y_s),
      .line_cnt_o   (line_cnt_s),
      .line_list_o  (line_list_s)
   );

   // Descending walk so the lowest line-list index is the last, winning, assignment.
   always_comb begin
      found_s = 1'b0;
      cov_s   = 1'b0;
      win_s   = '0;
      for (int i = LINE_SPRITES - 1; i >= 0; i--) begin
         cov_s   = (LW'(i) < line_cnt_s) && in_span(DW'(hcount_in), DW'(line_list_s[i].x));
         win_s   = cov_s ? line_list_s[i] : win_s;
         found_s = found_s | cov_s;
      end
      dx_s = hcount_in - win_s.x;
      dy_s = line_y_s - win_s.y;
      if (pixel_valid_in && line_ready_s && found_s) begin
         hit_d   = 1'b1;
         frame_d = win_s.frame;
         px_d    = dx_s[SW-1:0];
         py_d    = dy_s[SW-1:0];
      end else begin
         hit_d   = 1'b0;
         frame_d = FW'(0);
         px_d    = SW'(0);
         py_d    = SW'(0);
      end
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         hit_q   <= 1'b0;
         frame_q <= FW'(0);
         px_q    <= SW'(0);
         py_q    <= SW'(0);
      end else begin
         hit_q   <= hit_d;
         frame_q <= frame_d;
         px_q    <= px_d;
         py_q    <= py_d;
      end
   end

   assign sprite_hit_out   = hit_q;
   assign sprite_frame_out = frame_q;
   assign sprite_px_out    = px_q;
   assign sprite_py_out    = py_q;
   assign line_ready_out   = line_ready_s;
   assign list_ovf_out     = list_ovf_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized and directed bench for sprite_compositor against a queue-based list/line model.
module tb_sprite_compositor;
   import sprite_compositor_pkg::*;

   logic          pixel_clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          new_frame = 1'b0;
   logic [XW-1:0] x = '0;
   logic [YW-1:0] y = '0;
   logic [FW-1:0] frame = '0;
   logic          sprite_valid = 1'b0;
   logic          line_start_in = 1'b0;
   logic [YW-1:0] line_y_in = '0;
   logic          pixel_valid_in = 1'b0;
   logic [XW-1:0] hcount_in = '0;
   logic          sprite_hit_out;
   logic [FW-1:0] sprite_frame_out;
   logic [SW-1:0] sprite_px_out;
   logic [SW-1:0] sprite_py_out;
   logic          line_ready_out;
   logic          list_ovf_out;
   logic          line_ovf_out;

   always #5 pixel_clk_in = ~pixel_clk_in;

   sprite_compositor dut (
      .pixel_clk_in     (pixel_clk_in),
      .rst_in           (rst_in),
      .new_frame        (new_frame),
      .x                (x),
      .y                (y),
      .frame            (frame),
      .sprite_valid     (sprite_valid),
      .line_start_in    (line_start_in),
      .line_y_in        (line_y_in),
      .pixel_valid_in   (pixel_valid_in),
      .hcount_in        (hcount_in),
      .sprite_hit_out   (sprite_hit_out),
      .sprite_frame_out (sprite_frame_out),
      .sprite_px_out    (sprite_px_out),
      .sprite_py_out    (sprite_py_out),
      .line_ready_out   (line_ready_out),
      .list_ovf_out     (list_ovf_out),
      .line_ovf_out     (line_ovf_out)
   );

   typedef struct { int x; int y; int f; } spr_t;

   spr_t back_q[$];
   spr_t front_q[$];
   spr_t line_q[$];
   int   m_line_y = 0;
   bit   m_ready = 1'b0;
   bit   m_lovf = 1'b0;
   bit   m_line_ovf = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit covers(input int pos, input int org);
      return (pos >= org) && (pos - org < SPRITE_SIZE);
   endfunction

   task automatic step();
      @(posedge pixel_clk_in);
      #1;
   endtask

   task automatic model_clear();
      back_q.delete();
      front_q.delete();
      line_q.delete();
      m_ready = 1'b0;
      m_lovf = 1'b0;
      m_line_ovf = 1'b0;
   endtask

   task automatic cycle_in(input bit v, input bit nf, input int sx, input int sy, input int sf);
      sprite_valid = v;
      new_frame = nf;
      x = XW'(sx);
      y = YW'(sy);
      frame = FW'(sf);
      step();
      sprite_valid = 1'b0;
      new_frame = 1'b0;
      if (nf) begin
         front_q = back_q;
         back_q.delete();
         m_lovf = 1'b0;
         m_ready = 1'b0;
         line_q.delete();
      end
      if (v) begin
         if (back_q.size() < MAX_SPRITES) back_q.push_back('{sx, sy, sf});
         else m_lovf = 1'b1;
      end
      check_eq("list_ovf", int'(list_ovf_out), int'(m_lovf));
   endtask

   task automatic start_line(input int ly);
      line_start_in = 1'b1;
      line_y_in = YW'(ly);
      step();
      line_start_in = 1'b0;
      m_ready = 1'b0;
      m_line_y = ly;
      m_line_ovf = 1'b0;
      line_q.delete();
      foreach (front_q[i]) begin
         if (covers(ly, front_q[i].y)) begin
            if (line_q.size() < LINE_SPRITES) line_q.push_back(front_q[i]);
            else m_line_ovf = 1'b1;
         end
      end
      check_eq("ready_clr", int'(line_ready_out), 0);
   endtask

   task automatic scan_line(input int ly);
      int cyc;
      start_line(ly);
      cyc = 0;
      while (!line_ready_out && cyc < MAX_SPRITES + 8) begin
         step();
         cyc++;
      end
      check_eq("scan_cycles", cyc, front_q.size() + 1);
      m_ready = 1'b1;
      check_eq("line_ovf", int'(line_ovf_out), int'(m_line_ovf));
   endtask

   task automatic pixel(input int h, input bit pv);
      int eh, ef, epx, epy;
      pixel_valid_in = pv;
      hcount_in = XW'(h);
      step();
      pixel_valid_in = 1'b0;
      eh = 0; ef = 0; epx = 0; epy = 0;
      if (pv && m_ready) begin
         foreach (line_q[i]) begin
            if (eh == 0 && covers(h, line_q[i].x)) begin
               eh = 1;
               ef = line_q[i].f;
               epx = h - line_q[i].x;
               epy = m_line_y - line_q[i].y;
            end
         end
      end
      check_eq("hit", int'(sprite_hit_out), eh);
      check_eq("frame", int'(sprite_frame_out), ef);
      check_eq("px", int'(sprite_px_out), epx);
      check_eq("py", int'(sprite_py_out), epy);
      check_eq("ready", int'(line_ready_out), int'(m_ready));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_hit"}, int'(sprite_hit_out), 0);
      check_eq({tag, "_frame"}, int'(sprite_frame_out), 0);
      check_eq({tag, "_px"}, int'(sprite_px_out), 0);
      check_eq({tag, "_py"}, int'(sprite_py_out), 0);
      check_eq({tag, "_ready"}, int'(line_ready_out), 0);
      check_eq({tag, "_lovf"}, int'(list_ovf_out), 0);
      check_eq({tag, "_lnovf"}, int'(line_ovf_out), 0);
   endtask

   initial begin
      int n, ly, h, k;
      step();
      step();
      rst_in = 1'b0;
      model_clear();
      check_all_zero("por");

      // Reset mid-frame after three writes; the back list must come back empty.
      for (int i = 0; i < 3; i++) cycle_in(1'b1, 1'b0, 5 + i, 5, i);
      rst_in = 1'b1;
      #2;
      check_all_zero("arst");
      step();
      rst_in = 1'b0;
      model_clear();
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(5);
      pixel(6, 1'b1);

      // Single sprite.
      cycle_in(1'b1, 1'b0, 10, 20, 5);
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(25);
      pixel(13, 1'b1);
      pixel(26, 1'b1);
      pixel(13, 1'b0);
      pixel(10, 1'b1);

      // Overlapping sprites, earliest wins.
      cycle_in(1'b1, 1'b0, 10, 20, 1);
      cycle_in(1'b1, 1'b0, 12, 20, 2);
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(20);
      pixel(12, 1'b1);
      pixel(26, 1'b1);
      pixel(9, 1'b1);
      scan_line(35);
      pixel(12, 1'b1);

      // Line overflow with six sprites on one line.
      for (int i = 0; i < 6; i++) cycle_in(1'b1, 1'b0, i * 10, 0, 10 + i);
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(0);
      pixel(45, 1'b1);
      pixel(35, 1'b1);
      pixel(5, 1'b1);

      // List overflow on the 33rd descriptor, cleared by the swap.
      for (int i = 0; i < MAX_SPRITES + 1; i++)
         cycle_in(1'b1, 1'b0, $urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99));
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(50);
      pixel(50, 1'b1);

      // Descriptor coincident with new_frame.
      cycle_in(1'b1, 1'b1, 30, 40, 7);
      scan_line(45);
      pixel(32, 1'b1);
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      scan_line(45);
      pixel(32, 1'b1);

      // Restart mid-scan, then abort mid-scan with new_frame.
      for (int i = 0; i < 10; i++) cycle_in(1'b1, 1'b0, i * 9, 40 + i * 2, 20 + i);
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      start_line(45);
      step();
      step();
      scan_line(50);
      pixel(40, 1'b1);
      pixel(75, 1'b1);
      start_line(44);
      step();
      cycle_in(1'b0, 1'b1, 0, 0, 0);
      pixel(10, 1'b1);
      step();
      step();
      pixel(20, 1'b1);

      // Random frames.
      for (int it = 0; it < 20; it++) begin
         n = $urandom_range(0, MAX_SPRITES + 4);
         for (int i = 0; i < n; i++)
            cycle_in(1'b1, 1'b0, $urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99));
         cycle_in(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 99), $urandom_range(0, 99),
                  $urandom_range(0, 99));
         for (int l = 0; l < 3; l++) begin
            if (front_q.size() > 0) begin
               k = $urandom_range(0, front_q.size() - 1);
               ly = front_q[k].y + $urandom_range(0, SPRITE_SIZE - 1);
               if (ly > 99) ly = 99;
            end else begin
               ly = $urandom_range(0, 99);
            end
            scan_line(ly);
            for (int p = 0; p < 6; p++) begin
               if (line_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                  k = $urandom_range(0, line_q.size() - 1);
                  h = line_q[k].x + $urandom_range(0, SPRITE_SIZE + 1);
                  if (h > 99) h = 99;
               end else begin
                  h = $urandom_range(0, 99);
               end
               pixel(h, 1'($urandom_range(0, 4) != 0));
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
